// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg: shared bus widths, slave address windows and copy-master state codes.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 64;

    localparam logic [ADDR_W-1:0] S0_LO = 16'h0000;
    localparam logic [ADDR_W-1:0] S0_HI = 16'h07FF;
    localparam logic [ADDR_W-1:0] S1_LO = 16'h7000;
    localparam logic [ADDR_W-1:0] S1_HI = 16'h71FF;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd1;
    localparam logic [2:0] ST_REQ       = 3'd2;
    localparam logic [2:0] ST_RD        = 3'd3;
    localparam logic [2:0] ST_WR        = 3'd4;
    localparam logic [2:0] ST_FIN       = 3'd5;

endpackage

`default_nettype wire

// File: rtl/bus_addr_decode.sv
// ---------------------------------------------------------------------------
// bus_addr_decode: combinational address to slave-window hit decoder.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_addr_decode
    import bus_pkg::*;
(
    input  logic [ADDR_W-1:0] addr_i,
    output logic              s0_hit_o,
    output logic              s1_hit_o
);

    logic [ADDR_W-1:0] off0;
    logic [ADDR_W-1:0] off1;

    // Offset-from-base form keeps each range check a single unsigned compare.
    assign off0     = addr_i - S0_LO;
    assign off1     = addr_i - S1_LO;
    assign s0_hit_o = (off0 <= (S0_HI - S0_LO));
    assign s1_hit_o = (off1 <= (S1_HI - S1_LO));

endmodule

`default_nettype wire

// File: rtl/bus_copy_master.sv
// ---------------------------------------------------------------------------
// bus_copy_master: copies LEN words src->dst, one read + one write per word.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_copy_master
    import bus_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 2,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    input  logic              m_grant,
    input  logic [DATA_W-1:0] m_din
);

    localparam logic [7:0] RD_LAST = 8'(RD_LAT - 1);
    localparam logic [7:0] WR_LAST = 8'(WR_LAT - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              m_req_q, m_req_d;
    logic              m_wr_q, m_wr_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_dout_q, m_dout_d;
    logic              s0_hit, s1_hit, addr_bad;

    bus_addr_decode u_dec (
        .addr_i   (m_addr_q),
        .s0_hit_o (s0_hit),
        .s1_hit_o (s1_hit)
    );

    assign addr_bad = ~(s0_hit | s1_hit);

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        m_req_d  = m_req_q;
        m_wr_d   = m_wr_q;
        m_addr_d = m_addr_q;
        m_dout_d = m_dout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (len == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        rem_d   = len;
                        busy_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // A grant still high belongs to the previous transfer's tail.
                if (!m_grant) begin
                    m_req_d = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (m_grant) begin
                    m_addr_d = src_q;
                    m_wr_d   = 1'b0;
                    cnt_d    = 8'd0;
                    state_d  = ST_RD;
                end
            end
            ST_RD: begin
                if (addr_bad) err_d = 1'b1;
                if (cnt_q == RD_LAST) begin
                    // m_dout_q doubles as the word buffer between read and write.
                    m_dout_d = m_din;
                    m_addr_d = dst_q;
                    m_wr_d   = 1'b1;
                    cnt_d    = 8'd0;
                    state_d  = ST_WR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WR: begin
                if (addr_bad) err_d = 1'b1;
                if (cnt_q == WR_LAST) begin
                    m_wr_d = 1'b0;
                    rem_d  = rem_q - LEN_W'(1);
                    src_d  = src_q + 16'd1;
                    dst_d  = dst_q + 16'd1;
                    cnt_d  = 8'd0;
                    if (rem_q == LEN_W'(1)) begin
                        m_req_d = 1'b0;
                        state_d = ST_FIN;
                    end else begin
                        m_addr_d = src_q + 16'd1;
                        state_d  = ST_RD;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            m_req_q  <= 1'b0;
            m_wr_q   <= 1'b0;
            m_addr_q <= '0;
            m_dout_q <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            m_req_q  <= m_req_d;
            m_wr_q   <= m_wr_d;
            m_addr_q <= m_addr_d;
            m_dout_q <= m_dout_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign m_req  = m_req_q;
    assign m_wr   = m_wr_q;
    assign m_addr = m_addr_q;
    assign m_dout = m_dout_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_copy_master.sv
// ---------------------------------------------------------------------------
// tb_bus_copy_master: bus/slave model plus write scoreboard for bus_copy_master.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bus_copy_master;

    typedef struct packed {
        logic [15:0] a;
        logic [63:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] src_addr, dst_addr;
    logic [7:0]  len;
    logic        busy, done, err, m_req, m_wr, m_grant;
    logic [15:0] m_addr;
    logic [63:0] m_dout, m_din;

    logic        req_d1, grant_q, force_grant;
    logic [63:0] mem0 [0:2047];
    logic [63:0] mem1 [0:511];

    int tests_run = 0;
    int tests_failed = 0;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  c_done_cnt, c_done_cyc, c_req_cyc, c_wr_cyc, c_req_rises;
    bit  c_busy_seen, c_req_seen, c_err_at_done, c_req_at_done;

    always #5 clk = ~clk;

    bus_copy_master #(.RD_LAT(2), .WR_LAT(2), .LEN_W(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .m_req    (m_req),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_dout   (m_dout),
        .m_grant  (m_grant),
        .m_din    (m_din)
    );

    function automatic logic [63:0] seed0(input int i);
        if (i == 16) return 64'hDEADBEEF_00000001;
        return {16'hA0A0, 16'(i), 32'(i * 3 + 7)};
    endfunction

    function automatic logic [63:0] seed1(input int i);
        return {16'hB1B1, 16'(i), 32'hC0DE_0000 | 32'(i)};
    endfunction

    function automatic logic [63:0] model_read(input logic [15:0] a);
        if (a <= 16'h07FF) return mem0[a[10:0]];
        if (a >= 16'h7000 && a <= 16'h71FF) return mem1[a[8:0]];
        return 64'h0;
    endfunction

    // Bus model: grant two edges after request, data valid one edge after address.
    assign m_grant = grant_q | force_grant;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_d1  <= 1'b0;
            grant_q <= 1'b0;
            m_din   <= 64'h0;
            for (int i = 0; i < 2048; i++) mem0[i] <= seed0(i);
            for (int i = 0; i < 512; i++) mem1[i] <= seed1(i);
        end else begin
            req_d1  <= m_req;
            grant_q <= m_req & req_d1;
            m_din   <= model_read(m_addr);
            if (m_wr) begin
                if (m_addr <= 16'h07FF) mem0[m_addr[10:0]] <= m_dout;
                else if (m_addr >= 16'h7000 && m_addr <= 16'h71FF) mem1[m_addr[8:0]] <= m_dout;
            end
        end
    end

    task automatic push_expect(input logic [15:0] s, input logic [15:0] d, input int n);
        wr_t w;
        for (int k = 0; k < n; k++) begin
            w.a = 16'(d + 16'(k));
            w.d = model_read(16'(s + 16'(k)));
            exp_q.push_back(w);
        end
    endtask

    task automatic kick(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Samples bus activity each negedge until two cycles past the first done.
    task automatic collect(input int budget, input int inject_cyc);
        wr_t w;
        bit  prev_wr, prev_req;
        prev_wr = 1'b0; prev_req = 1'b0;
        c_done_cnt = 0; c_done_cyc = -1; c_req_cyc = 0; c_wr_cyc = 0; c_req_rises = 0;
        c_busy_seen = 0; c_req_seen = 0; c_err_at_done = 0; c_req_at_done = 0;
        obs_q.delete();
        for (int cyc = 0; cyc <= budget; cyc++) begin
            if (cyc == inject_cyc) begin
                start = 1'b1; src_addr = 16'h0300; dst_addr = 16'h0310; len = 8'd5;
            end else begin
                start = 1'b0;
            end
            if (m_req) c_req_cyc++;
            if (m_wr) c_wr_cyc++;
            if (m_req && !prev_req) c_req_rises++;
            if (busy) c_busy_seen = 1;
            if (m_req) c_req_seen = 1;
            if (m_wr && !prev_wr) begin
                w.a = m_addr; w.d = m_dout;
                obs_q.push_back(w);
            end
            prev_wr = m_wr; prev_req = m_req;
            if (done) begin
                if (c_done_cnt == 0) begin
                    c_done_cyc = cyc; c_err_at_done = err; c_req_at_done = m_req;
                end
                c_done_cnt++;
            end
            if (c_done_cnt > 0 && cyc >= c_done_cyc + 2) break;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({busy, done, err, m_req, m_wr} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b, want 00000", {busy, done, err, m_req, m_wr});
        end
        tests_run++;
        if ({m_addr, m_dout} !== 80'h0) begin
            tests_failed++;
            $display("FAIL reset_bus: got addr %h dout %h, want 0", m_addr, m_dout);
        end
    endtask

    task automatic test_single();
        wr_t e, o;
        push_expect(16'h0010, 16'h0020, 1);
        kick(16'h0010, 16'h0020, 8'd1);
        collect(60, -1);
        tests_run++;
        if (obs_q.size() != 1) begin
            tests_failed++;
            $display("FAIL single_nwr: got %0d writes, want 1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== {16'h0020, 64'hDEADBEEF_00000001}) begin
                tests_failed++;
                $display("FAIL single_wr: got %h/%h, want 0020/deadbeef00000001 (model %h)", o.a, o.d, e.d);
            end
        end
        tests_run++;
        if (c_done_cnt != 1 || c_done_cyc != 9) begin
            tests_failed++;
            $display("FAIL single_done: got cnt %0d at cyc %0d, want 1 at 9", c_done_cnt, c_done_cyc);
        end
        tests_run++;
        if (c_err_at_done !== 1'b0 || c_req_at_done !== 1'b0 || c_wr_cyc != 2) begin
            tests_failed++;
            $display("FAIL single_flags: got err %b req %b wrcyc %0d, want 0 0 2",
                     c_err_at_done, c_req_at_done, c_wr_cyc);
        end
        exp_q.delete();
    endtask

    task automatic test_multi();
        wr_t e, o;
        push_expect(16'h7000, 16'h0100, 4);
        kick(16'h7000, 16'h0100, 8'd4);
        collect(100, -1);
        tests_run++;
        if (obs_q.size() != 4) begin
            tests_failed++;
            $display("FAIL multi_nwr: got %0d writes, want 4", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL multi_wr: got %h/%h, want %h/%h", o.a, o.d, e.a, e.d);
            end
        end
        tests_run++;
        if (c_req_cyc != 3 + 4 * 4 || c_req_rises != 1 || c_done_cyc != 5 + 4 * 4) begin
            tests_failed++;
            $display("FAIL multi_timing: got req %0d rises %0d done@%0d, want 19 1 21",
                     c_req_cyc, c_req_rises, c_done_cyc);
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (mem0[256 + k] !== seed1(k)) begin
                tests_failed++;
                $display("FAIL multi_mem%0d: got %h, want %h", k, mem0[256 + k], seed1(k));
            end
        end
        exp_q.delete();
    endtask

    task automatic test_len0();
        kick(16'h0010, 16'h0020, 8'd0);
        collect(20, -1);
        tests_run++;
        if (c_done_cnt != 1 || c_done_cyc != 1) begin
            tests_failed++;
            $display("FAIL len0_done: got cnt %0d at cyc %0d, want 1 at 1", c_done_cnt, c_done_cyc);
        end
        tests_run++;
        if (c_busy_seen || c_req_seen || obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL len0_idle: got busy %b req %b writes %0d, want 0 0 0",
                     c_busy_seen, c_req_seen, obs_q.size());
        end
    endtask

    task automatic test_err();
        wr_t e, o;
        push_expect(16'h07FF, 16'h0200, 2);
        kick(16'h07FF, 16'h0200, 8'd2);
        collect(80, -1);
        tests_run++;
        if (obs_q.size() != 2) begin
            tests_failed++;
            $display("FAIL err_nwr: got %0d writes, want 2", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL err_wr: got %h/%h, want %h/%h", o.a, o.d, e.a, e.d);
            end
        end
        tests_run++;
        if (c_err_at_done !== 1'b1 || mem0[513] !== 64'h0) begin
            tests_failed++;
            $display("FAIL err_set: got err %b word %h, want 1 0", c_err_at_done, mem0[513]);
        end
        exp_q.delete();
        kick(16'h0011, 16'h0210, 8'd1);
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_clear: got %b, want 0", err);
        end
        collect(60, -1);
        tests_run++;
        if (c_err_at_done !== 1'b0 || c_done_cnt != 1) begin
            tests_failed++;
            $display("FAIL err_next: got err %b done %0d, want 0 1", c_err_at_done, c_done_cnt);
        end
    endtask

    task automatic test_busy_start();
        wr_t e, o;
        push_expect(16'h0030, 16'h0040, 2);
        kick(16'h0030, 16'h0040, 8'd2);
        collect(80, 3);
        tests_run++;
        if (obs_q.size() != 2 || c_done_cnt != 1) begin
            tests_failed++;
            $display("FAIL busy_nwr: got %0d writes %0d dones, want 2 1", obs_q.size(), c_done_cnt);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL busy_wr: got %h/%h, want %h/%h", o.a, o.d, e.a, e.d);
            end
        end
        repeat (10) @(negedge clk);
        tests_run++;
        if (m_req !== 1'b0 || busy !== 1'b0 || mem0[784] !== seed0(784)) begin
            tests_failed++;
            $display("FAIL busy_drop: got req %b busy %b word %h, want 0 0 %h",
                     m_req, busy, mem0[784], seed0(784));
        end
        exp_q.delete();
    endtask

    task automatic test_wait_grant();
        wr_t e, o;
        bit  req_early;
        req_early = 0;
        force_grant = 1'b1;
        push_expect(16'h0040, 16'h0050, 1);
        kick(16'h0040, 16'h0050, 8'd1);
        repeat (6) begin
            @(negedge clk);
            if (m_req) req_early = 1;
        end
        tests_run++;
        if (req_early || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL wait_grant: got early req %b busy %b, want 0 1", req_early, busy);
        end
        force_grant = 1'b0;
        collect(60, -1);
        tests_run++;
        if (obs_q.size() != 1 || c_done_cnt != 1) begin
            tests_failed++;
            $display("FAIL wait_nwr: got %0d writes %0d dones, want 1 1", obs_q.size(), c_done_cnt);
        end
        if (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL wait_wr: got %h/%h, want %h/%h", o.a, o.d, e.a, e.d);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        wr_t o;
        bit  found, saw_done;
        found = 0; saw_done = 0;
        kick(16'h0050, 16'h0060, 8'd3);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_wr) begin found = 1; break; end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL rstmid_wr: got no write beat within 40 cycles, want one");
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, err, m_req, m_wr, m_addr, m_dout} !== 85'h0) begin
            tests_failed++;
            $display("FAIL rstmid_async: got ctrl %b addr %h dout %h, want all 0",
                     {busy, done, err, m_req, m_wr}, m_addr, m_dout);
        end
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        tests_run++;
        if (saw_done) begin
            tests_failed++;
            $display("FAIL rstmid_nodone: got done pulse, want none");
        end
        exp_q.delete();
        kick(16'h0010, 16'h0070, 8'd1);
        collect(60, -1);
        tests_run++;
        if (obs_q.size() != 1 || c_done_cnt != 1) begin
            tests_failed++;
            $display("FAIL rstmid_nwr: got %0d writes %0d dones, want 1 1", obs_q.size(), c_done_cnt);
        end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            tests_run++;
            if (o !== {16'h0070, 64'hDEADBEEF_00000001}) begin
                tests_failed++;
                $display("FAIL rstmid_wr2: got %h/%h, want 0070/deadbeef00000001", o.a, o.d);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; src_addr = 16'h0; dst_addr = 16'h0;
        len = 8'd0; force_grant = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_multi();
        test_len0();
        test_err();
        test_busy_start();
        test_wait_grant();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
